// File: rtl/cue_aim_controller.sv
// Shot-aim controller for the cue ball: turns held direction keys into a
// saturated signed X/Y launch velocity, fires one load strobe on an Enter
// edge, then holds off re-aiming until the cooldown has elapsed and the
// table is still.
//
// state | meaning
// IDLE  | aiming not allowed, velocity held at zero
// AIM   | per-frame key integration with acceleration and clamping
// FIRE  | single cycle, velocityWriteEnable asserted with the frozen vector
// WAIT  | velocity cleared, cooldown frames counted, waits for table to settle
module cue_aim_controller #(
  parameter int VEL_W           = 11,
  parameter int VEL_LIMIT       = 200,
  parameter int STEP_MIN        = 1,
  parameter int STEP_MAX        = 4,
  parameter int ACCEL_FRAMES    = 16,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    aimEnable,
  input  logic                    startOfFrame,
  input  logic                    key2IsPressed,
  input  logic                    key8IsPressed,
  input  logic                    key4IsPressed,
  input  logic                    key6IsPressed,
  input  logic                    keyEnterIsPressed,
  input  logic                    ballsMoving,
  output logic signed [VEL_W-1:0] newVelocityX,
  output logic signed [VEL_W-1:0] newVelocityY,
  output logic                    velocityWriteEnable,
  output logic [1:0]              aimState
);

  // Two guard bits keep value +/- STEP_MAX from wrapping before the clamp.
  localparam int EXT_W  = VEL_W + 2;
  localparam int HOLD_W = $clog2(ACCEL_FRAMES + 1);
  localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [HOLD_W-1:0]       HOLD_SAT  = HOLD_W'(ACCEL_FRAMES);
  localparam logic [COOL_W-1:0]       COOL_SAT  = COOL_W'(COOLDOWN_FRAMES);
  localparam logic signed [EXT_W-1:0] STEP_SLOW = EXT_W'(STEP_MIN);
  localparam logic signed [EXT_W-1:0] STEP_FAST = EXT_W'(STEP_MAX);
  localparam logic signed [EXT_W-1:0] LIMIT_HI  = EXT_W'(VEL_LIMIT);
  localparam logic signed [EXT_W-1:0] LIMIT_LO  = -LIMIT_HI;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AIM  = 2'd1,
    FIRE = 2'd2,
    WAIT = 2'd3
  } aimPhase_t;

  aimPhase_t state, nextState;

  logic signed [VEL_W-1:0] velX, velY;
  logic signed [VEL_W-1:0] stepVelX, stepVelY;
  logic [HOLD_W-1:0]       holdX, holdY;
  logic [HOLD_W-1:0]       stepHoldX, stepHoldY;
  logic [COOL_W-1:0]       coolCnt;
  logic                    enterPrev;
  logic                    enterRise;
  logic                    aimNonZero;
  logic                    fireRequest;
  logic                    cooldownDone;

  // Next velocity for one axis: step sized by the pre-increment hold count,
  // computed wide and clamped so the output never exceeds the limit.
  function automatic logic signed [VEL_W-1:0] axisVel(
    input logic signed [VEL_W-1:0] cur,
    input logic                    plusKey,
    input logic                    minusKey,
    input logic [HOLD_W-1:0]       hold
  );
    logic signed [EXT_W-1:0] wide;
    logic signed [EXT_W-1:0] step;
    logic signed [EXT_W-1:0] sum;
    wide = {{2{cur[VEL_W-1]}}, cur};
    step = (hold < HOLD_SAT) ? STEP_SLOW : STEP_FAST;
    sum  = wide;
    if (plusKey && !minusKey) begin
      sum = wide + step;
    end else if (minusKey && !plusKey) begin
      sum = wide - step;
    end
    if (sum > LIMIT_HI) begin
      sum = LIMIT_HI;
    end else if (sum < LIMIT_LO) begin
      sum = LIMIT_LO;
    end
    return sum[VEL_W-1:0];
  endfunction

  // Hold counter: counts frames with exactly one key of the pair held.
  function automatic logic [HOLD_W-1:0] axisHold(
    input logic              plusKey,
    input logic              minusKey,
    input logic [HOLD_W-1:0] hold
  );
    if (plusKey == minusKey) begin
      return '0;
    end
    if (hold == HOLD_SAT) begin
      return hold;
    end
    return hold + HOLD_W'(1);
  endfunction

  assign stepVelX  = axisVel(velX, key6IsPressed, key4IsPressed, holdX);
  assign stepVelY  = axisVel(velY, key2IsPressed, key8IsPressed, holdY);
  assign stepHoldX = axisHold(key6IsPressed, key4IsPressed, holdX);
  assign stepHoldY = axisHold(key2IsPressed, key8IsPressed, holdY);

  // enterPrev resets high so an Enter already held at reset cannot fire.
  assign enterRise    = keyEnterIsPressed & ~enterPrev;
  assign aimNonZero   = (velX != '0) || (velY != '0);
  assign fireRequest  = enterRise && aimNonZero;
  assign cooldownDone = (coolCnt == COOL_SAT) && !ballsMoving;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; in AIM, losing aimEnable outranks a fire request.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (aimEnable) nextState = AIM;
      AIM: begin
        if (!aimEnable) begin
          nextState = IDLE;
        end else if (fireRequest) begin
          nextState = FIRE;
        end
      end
      FIRE: nextState = WAIT;
      WAIT: begin
        if (cooldownDone) begin
          nextState = aimEnable ? AIM : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from registered state only, so the strobe is glitch-free.
  always_comb begin
    velocityWriteEnable = (state == FIRE);
    aimState            = state;
    newVelocityX        = velX;
    newVelocityY        = velY;
  end

  // Velocity, hold and cooldown datapath; a fire request discards the frame update.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      velX      <= '0;
      velY      <= '0;
      holdX     <= '0;
      holdY     <= '0;
      coolCnt   <= '0;
      enterPrev <= 1'b1;
    end else begin
      enterPrev <= keyEnterIsPressed;
      case (state)
        IDLE: begin
          velX  <= '0;
          velY  <= '0;
          holdX <= '0;
          holdY <= '0;
        end
        AIM: begin
          if (!aimEnable) begin
            velX  <= '0;
            velY  <= '0;
            holdX <= '0;
            holdY <= '0;
          end else if (!fireRequest && startOfFrame) begin
            velX  <= stepVelX;
            velY  <= stepVelY;
            holdX <= stepHoldX;
            holdY <= stepHoldY;
          end
        end
        FIRE: begin
          velX    <= '0;
          velY    <= '0;
          holdX   <= '0;
          holdY   <= '0;
          coolCnt <= '0;
        end
        WAIT: begin
          if (startOfFrame && (coolCnt != COOL_SAT)) begin
            coolCnt <= coolCnt + COOL_W'(1);
          end
        end
        default: begin
          velX <= '0;
          velY <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cue_aim_controller.sv
// Bench for cue_aim_controller: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a behavioural model.
module tb_cue_aim_controller;

  localparam int VEL_W = 11;
  localparam int LIMIT = 200;
  localparam int SMIN  = 1;
  localparam int SMAX  = 4;
  localparam int ACCEL = 16;
  localparam int COOL  = 30;

  localparam int P_IDLE = 0;
  localparam int P_AIM  = 1;
  localparam int P_FIRE = 2;
  localparam int P_WAIT = 3;

  logic clk = 1'b0;
  logic resetN, aimEnable, startOfFrame;
  logic key2IsPressed, key8IsPressed, key4IsPressed, key6IsPressed;
  logic keyEnterIsPressed, ballsMoving;
  logic signed [VEL_W-1:0] newVelocityX, newVelocityY;
  logic velocityWriteEnable;
  logic [1:0] aimState;

  int nChecks = 0;
  int nFail   = 0;

  // behavioural model state
  int mPhase = 0, mVx = 0, mVy = 0, mHx = 0, mHy = 0, mFrames = 0;
  bit mPrevEnter = 1'b1;
  int minY = 0;

  typedef struct {
    int rst, aim, sof, k2, k8, k4, k6, ent, balls;
    int ex, ey, we, st;
  } vec_t;

  vec_t tbl[17];

  cue_aim_controller #(
    .VEL_W(VEL_W), .VEL_LIMIT(LIMIT), .STEP_MIN(SMIN), .STEP_MAX(SMAX),
    .ACCEL_FRAMES(ACCEL), .COOLDOWN_FRAMES(COOL)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .aimEnable(aimEnable),
    .startOfFrame(startOfFrame),
    .key2IsPressed(key2IsPressed),
    .key8IsPressed(key8IsPressed),
    .key4IsPressed(key4IsPressed),
    .key6IsPressed(key6IsPressed),
    .keyEnterIsPressed(keyEnterIsPressed),
    .ballsMoving(ballsMoving),
    .newVelocityX(newVelocityX),
    .newVelocityY(newVelocityY),
    .velocityWriteEnable(velocityWriteEnable),
    .aimState(aimState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mAxis(input bit plus, input bit minus, inout int v, inout int h);
    int step;
    if (plus != minus) begin
      step = (h < ACCEL) ? SMIN : SMAX;
      if (h < ACCEL) h++;
      v = plus ? v + step : v - step;
      if (v > LIMIT) v = LIMIT;
      if (v < -LIMIT) v = -LIMIT;
    end else begin
      h = 0;
    end
  endtask

  // Reference: what one clock edge should do given the current inputs.
  task automatic mStep();
    bit rise, leave;
    if (!resetN) begin
      mPhase = P_IDLE; mVx = 0; mVy = 0; mHx = 0; mHy = 0; mFrames = 0;
      mPrevEnter = 1'b1;
    end else begin
      rise = keyEnterIsPressed && !mPrevEnter;
      case (mPhase)
        P_IDLE: begin
          mVx = 0; mVy = 0; mHx = 0; mHy = 0;
          if (aimEnable) mPhase = P_AIM;
        end
        P_AIM: begin
          if (!aimEnable) begin
            mPhase = P_IDLE; mVx = 0; mVy = 0; mHx = 0; mHy = 0;
          end else if (rise && (mVx != 0 || mVy != 0)) begin
            mPhase = P_FIRE;
          end else if (startOfFrame) begin
            mAxis(key6IsPressed, key4IsPressed, mVx, mHx);
            mAxis(key2IsPressed, key8IsPressed, mVy, mHy);
          end
        end
        P_FIRE: begin
          mPhase = P_WAIT; mVx = 0; mVy = 0; mHx = 0; mHy = 0; mFrames = 0;
        end
        default: begin
          leave = (mFrames >= COOL) && !ballsMoving;
          if (startOfFrame) mFrames++;
          if (leave) mPhase = aimEnable ? P_AIM : P_IDLE;
        end
      endcase
      mPrevEnter = keyEnterIsPressed;
    end
  endtask

  task automatic tick();
    mStep();
    @(posedge clk);
    #1;
    chk("model_velX", int'(newVelocityX), mVx);
    chk("model_velY", int'(newVelocityY), mVy);
    chk("model_we", int'(velocityWriteEnable), (mPhase == P_FIRE) ? 1 : 0);
    chk("model_state", int'(aimState), mPhase);
    if (int'(newVelocityY) < minY) minY = int'(newVelocityY);
  endtask

  task automatic clearIn();
    startOfFrame = 0; key2IsPressed = 0; key8IsPressed = 0;
    key4IsPressed = 0; key6IsPressed = 0; keyEnterIsPressed = 0; ballsMoving = 0;
  endtask

  task automatic frame();
    startOfFrame = 1; tick();
    startOfFrame = 0; tick();
  endtask

  task automatic doReset();
    clearIn();
    resetN = 0; aimEnable = 0; tick();
    resetN = 1; aimEnable = 1; tick();
  endtask

  task automatic setIn(input vec_t v);
    resetN = (v.rst != 0); aimEnable = (v.aim != 0); startOfFrame = (v.sof != 0);
    key2IsPressed = (v.k2 != 0); key8IsPressed = (v.k8 != 0);
    key4IsPressed = (v.k4 != 0); key6IsPressed = (v.k6 != 0);
    keyEnterIsPressed = (v.ent != 0); ballsMoving = (v.balls != 0);
  endtask

  initial begin
    //            rst aim sof k2 k8 k4 k6 ent bal   ex ey we st
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1};
    tbl[2]  = '{1, 1, 1, 0, 0, 0, 1, 0, 0,  1, 0, 0, 1};
    tbl[3]  = '{1, 1, 1, 0, 0, 0, 1, 0, 0,  2, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0,  2, 0, 0, 1};
    tbl[5]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1};
    tbl[6]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1};
    tbl[7]  = '{1, 1, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 2};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3};
    tbl[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1};
    tbl[14] = '{1, 1, 1, 0, 0, 0, 1, 1, 0,  1, 0, 0, 1};
    tbl[15] = '{1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0};

    clearIn();
    resetN = 0; aimEnable = 0;
    tick();
    chk("reset_state", int'(aimState), 0);
    chk("reset_we", int'(velocityWriteEnable), 0);

    for (int i = 0; i < 17; i++) begin
      setIn(tbl[i]);
      tick();
      chk($sformatf("tbl%0d_velX", i), int'(newVelocityX), tbl[i].ex);
      chk($sformatf("tbl%0d_velY", i), int'(newVelocityY), tbl[i].ey);
      chk($sformatf("tbl%0d_we", i), int'(velocityWriteEnable), tbl[i].we);
      chk($sformatf("tbl%0d_state", i), int'(aimState), tbl[i].st);
    end

    // acceleration: 16 slow frames then 4 fast frames
    doReset();
    key6IsPressed = 1;
    for (int i = 0; i < 20; i++) frame();
    chk("accel_velX", int'(newVelocityX), 32);
    chk("accel_velY", int'(newVelocityY), 0);
    chk("accel_state", int'(aimState), 1);

    // negative saturation, then both-keys clears the hold counter
    key6IsPressed = 0; key8IsPressed = 1; minY = 0;
    for (int i = 0; i < 100; i++) frame();
    chk("sat_velY", int'(newVelocityY), -200);
    chk("sat_minY", minY, -200);
    key2IsPressed = 1; frame();
    chk("both_velY", int'(newVelocityY), -200);
    key8IsPressed = 0; frame();
    chk("holdclr_velY", int'(newVelocityY), -199);
    key2IsPressed = 0;

    // fire with velX = 10, held Enter gives no second strobe
    doReset();
    key6IsPressed = 1;
    for (int i = 0; i < 10; i++) frame();
    key6IsPressed = 0;
    keyEnterIsPressed = 1; tick();
    chk("fire_we", int'(velocityWriteEnable), 1);
    chk("fire_velX", int'(newVelocityX), 10);
    chk("fire_state", int'(aimState), 2);
    tick();
    chk("post_we", int'(velocityWriteEnable), 0);
    chk("post_velX", int'(newVelocityX), 0);
    chk("post_state", int'(aimState), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_we", int'(velocityWriteEnable), 0);
    end
    keyEnterIsPressed = 0;

    // cooldown with balls moving past 30 frames, released on frame 40
    ballsMoving = 1;
    for (int i = 1; i <= 40; i++) begin
      startOfFrame = 1;
      if (i == 40) ballsMoving = 0;
      tick();
      startOfFrame = 0;
      if (i < 40) begin
        chk("moving_state", int'(aimState), 3);
        tick();
      end
    end
    chk("release_state", int'(aimState), 1);

    // cooldown with table still: exit right after the 30th frame
    key6IsPressed = 1; frame(); key6IsPressed = 0;
    keyEnterIsPressed = 1; tick();
    chk("fire2_state", int'(aimState), 2);
    keyEnterIsPressed = 0; tick();
    for (int i = 1; i <= 30; i++) begin
      startOfFrame = 1; tick();
      chk("cool_state", int'(aimState), 3);
      startOfFrame = 0; tick();
      chk("cool_exit", int'(aimState), (i < 30) ? 3 : 1);
    end

    // Enter on zero vector is ignored
    keyEnterIsPressed = 1; tick();
    chk("zero_we", int'(velocityWriteEnable), 0);
    chk("zero_state", int'(aimState), 1);
    keyEnterIsPressed = 0; tick();

    // reset during FIRE, Enter held through release
    key6IsPressed = 1; frame(); key6IsPressed = 0;
    keyEnterIsPressed = 1; tick();
    chk("rfire_state", int'(aimState), 2);
    resetN = 0; tick();
    chk("rst_we", int'(velocityWriteEnable), 0);
    chk("rst_state", int'(aimState), 0);
    chk("rst_velX", int'(newVelocityX), 0);
    resetN = 1; tick();
    key6IsPressed = 1; frame(); key6IsPressed = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("noreFire_we", int'(velocityWriteEnable), 0);
      chk("noreFire_state", int'(aimState), 1);
    end
    keyEnterIsPressed = 0;

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      resetN       = ($urandom_range(0, 149) != 0);
      aimEnable    = ($urandom_range(0, 9) != 0);
      startOfFrame = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) key2IsPressed = ~key2IsPressed;
      if ($urandom_range(0, 7) == 0) key8IsPressed = ~key8IsPressed;
      if ($urandom_range(0, 7) == 0) key4IsPressed = ~key4IsPressed;
      if ($urandom_range(0, 7) == 0) key6IsPressed = ~key6IsPressed;
      if ($urandom_range(0, 9) == 0) keyEnterIsPressed = ~keyEnterIsPressed;
      if ($urandom_range(0, 39) == 0) ballsMoving = ~ballsMoving;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/cue_aim_controller.md
# cue_aim_controller

Parametrised shot-aim controller for the cue ball. While aiming is enabled it turns held direction keys into a signed X/Y launch velocity, updated once per video frame. Holding a key accelerates the adjustment, and the velocity saturates cleanly at a configurable limit. A debounced Enter issues a single velocity write to the ball, and a cooldown then blocks re-aiming until the table settles. It sits between the keyboard decoder and the ball's velocity-load port, and replaces the fixed-width single-rate aim logic.

## Interface
Parameters:
- VEL_W, 11: width of signed velocity outputs.
- VEL_LIMIT, 200: saturation magnitude; must satisfy VEL_LIMIT ≤ 2^(VEL_W-1)-1.
- STEP_MIN, 1: per-frame step before acceleration.
- STEP_MAX, 4: per-frame step once accelerated.
- ACCEL_FRAMES, 16: consecutive held frames before the step switches to STEP_MAX.
- COOLDOWN_FRAMES, 30: minimum frames spent in WAIT after a shot.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, synchronous active-low.
- aimEnable  in  1  aiming allowed (cue line visible).
- startOfFrame  in  1  one-cycle pulse per frame.
- key2IsPressed / key8IsPressed  in  1 each  +Y / −Y.
- key4IsPressed / key6IsPressed  in  1 each  −X / +X.
- keyEnterIsPressed  in  1  fire key, level.
- ballsMoving  in  1  any ball has nonzero velocity.
- newVelocityX, newVelocityY  out  VEL_W signed  current aim velocity.
- velocityWriteEnable  out  1  one-cycle load strobe to the ball.
- aimState  out  2  state encoding: IDLE=0, AIM=1, FIRE=2, WAIT=3.

## Operation
- All state is updated on posedge clk. Reset is sampled on clk.
- Reset values: state IDLE, velX/velY 0, both hold counters 0, cooldown counter 0, enterPrev 1, velocityWriteEnable 0.
- Enter edge detection: enterRise = keyEnterIsPressed & !enterPrev. enterPrev is updated every cycle. Because enterPrev resets to 1, an Enter that is already held at reset never fires.
- IDLE: velocities are held at 0. Goes to AIM when aimEnable=1.
- AIM, on each startOfFrame cycle, per axis:
  - Exactly one key of the pair pressed: the hold counter increments, saturating at ACCEL_FRAMES.
  - Step size: STEP_MIN while counter < ACCEL_FRAMES, otherwise STEP_MAX.
  - Both keys or neither pressed: no change on that axis, and the hold counter clears.
  - New value is computed in VEL_W+2 bits and then clamped to [−VEL_LIMIT, +VEL_LIMIT]. The clamp applies to the new value, so the output never exceeds the limit, even for one frame.
- AIM, other transitions:
  - aimEnable=0: go to IDLE, velocities and hold counters cleared. This has priority over Enter.
  - enterRise with (velX,velY)≠(0,0): go to FIRE; the velocity is frozen.
  - enterRise with a zero vector: ignored, stay in AIM.
  - enterRise coinciding with startOfFrame: go to FIRE with the pre-update velocity; the frame update is discarded.
- FIRE: lasts exactly one cycle. velocityWriteEnable=1 while the outputs carry the frozen vector. Next state is WAIT.
- WAIT:
  - Entry clears velocities to 0 and the cooldown counter to 0.
  - The cooldown counter increments on each startOfFrame, saturating at COOLDOWN_FRAMES.
  - Exit when counter = COOLDOWN_FRAMES and ballsMoving=0: go to AIM if aimEnable=1, else IDLE.
  - Keys, Enter and aimEnable changes are otherwise ignored.
- resetN low in any state, including FIRE, forces the reset values next cycle. A strobe cut short by reset is not reissued.

## Timing
- Key effect: a startOfFrame in cycle n is visible on newVelocityX/Y in cycle n+1.
- Fire latency: enterRise in cycle n gives state FIRE and velocityWriteEnable=1 in cycle n+1; both fall in cycle n+2.
- velocityWriteEnable is decoded from the registered state. It is glitch-free and never asserted for two consecutive cycles.
- Minimum shot-to-reaim spacing: COOLDOWN_FRAMES frames plus one cycle.

## Test plan
- Reset, then aimEnable=1, hold key6 for 20 frames (ACCEL_FRAMES=16) -> velX = 16×1 + 4×4 = 32, velY=0, aimState=1.
- Hold key8 for 100 frames -> velY reaches −200 and stays there; no sample ever shows < −200. Release, then press key8 and key2 together -> velY unchanged and hold counter cleared.
- velX=10, pulse Enter -> velocityWriteEnable high for exactly 1 cycle, one cycle after the edge, with newVelocityX=10. The next cycle outputs are 0 and aimState=3. Holding Enter afterwards produces no second strobe.
- Enter on a zero vector -> no strobe, remains AIM. Enter in the same cycle as aimEnable falling -> IDLE, no strobe.
- WAIT with ballsMoving=1 beyond 30 frames -> stays WAIT. Drop ballsMoving on frame 40 -> AIM next cycle. With ballsMoving=0 throughout -> exit exactly after the 30th startOfFrame.
- Assert resetN=0 during FIRE -> next cycle strobe 0, state IDLE, velocities 0. Enter held through the reset release -> no fire.
